// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes driven into the ALU, operation classes
// from the main decoder, and the funct3 values the ALU decode cares about.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_IARITH = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_control.sv
// Combinational translation of the decoder's ALU operation class plus funct
// fields into the 4-bit ALU control code.
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_e'(alu_op_i))
      ALUOP_LDST:   alu_ctrl_o = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3_i)
          F3_ADDSUB: alu_ctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_ctrl_o = ALU_AND;
          F3_OR:     alu_ctrl_o = ALU_OR;
          default:   alu_ctrl_o = ALU_ADD;
        endcase
      end
      ALUOP_IARITH: begin
        // bit 30 of an I-type is immediate data, so it never selects SUB here
        case (funct3_i)
          F3_AND:  alu_ctrl_o = ALU_AND;
          F3_OR:   alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU control decode at capture and EX/MEM,
// MEM/WB operand forwarding resolved combinationally in the EX cycle.
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic [2:0]        id_funct3_i,
  input  logic              id_funct7b5_i,
  input  logic              id_alu_src_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              id_branch_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              regwrite_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic              memtoreg_o,
  output logic              branch_o
);

  logic [3:0]        id_alu_ctrl;

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [REG_AW-1:0] rs1_q,      rs1_d;
  logic [REG_AW-1:0] rs2_q,      rs2_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              alu_src_q,  alu_src_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              branch_q,   branch_d;

  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;

  alu_control u_alu_control (
    .alu_op_i   (id_alu_op_i),
    .funct3_i   (id_funct3_i),
    .funct7b5_i (id_funct7b5_i),
    .alu_ctrl_o (id_alu_ctrl)
  );

  always_comb begin
    valid_d    = valid_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_src_d  = alu_src_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    branch_d   = branch_q;
    // flush outranks stall, so a stalled bubble request still empties the stage
    if (flush_i) begin
      valid_d    = 1'b0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      alu_ctrl_d = '0;
      alu_src_d  = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      branch_d   = 1'b0;
    end else if (!stall_i) begin
      valid_d    = id_valid_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      alu_ctrl_d = id_alu_ctrl;
      alu_src_d  = id_alu_src_i  & id_valid_i;
      regwrite_d = id_regwrite_i & id_valid_i;
      memread_d  = id_memread_i  & id_valid_i;
      memwrite_d = id_memwrite_i & id_valid_i;
      memtoreg_d = id_memtoreg_i & id_valid_i;
      branch_d   = id_branch_i   & id_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_ctrl_q <= '0;
      alu_src_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      branch_q   <= branch_d;
    end
  end

  // Older producer (MEM/WB) only applies when the younger one does not match.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                               input logic [DATA_W-1:0] rf);
    logic [DATA_W-1:0] v;
    v = rf;
    if (rs != '0) begin
      if (exmem_regwrite_i && (exmem_rd_i == rs))      v = exmem_result_i;
      else if (memwb_regwrite_i && (memwb_rd_i == rs)) v = memwb_data_i;
    end
    return v;
  endfunction

  always_comb begin
    rs1_fwd = fwd_sel(rs1_q, rs1_data_q);
    rs2_fwd = fwd_sel(rs2_q, rs2_data_q);
  end

  assign valid_o      = valid_q;
  assign a_o          = rs1_fwd;
  assign b_o          = alu_src_q ? imm_q : rs2_fwd;
  assign store_data_o = rs2_fwd;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign rd_o         = rd_q;
  assign regwrite_o   = regwrite_q;
  assign memread_o    = memread_q;
  assign memwrite_o   = memwrite_q;
  assign memtoreg_o   = memtoreg_q;
  assign branch_o     = branch_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model of the stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, id_valid_i;
  logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [1:0]  id_alu_op_i;
  logic [2:0]  id_funct3_i;
  logic        id_funct7b5_i, id_alu_src_i, id_regwrite_i, id_memread_i;
  logic        id_memwrite_i, id_memtoreg_i, id_branch_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [63:0] exmem_result_i, memwb_data_i;
  logic        valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o;
  logic [63:0] a_o, b_o, store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  rd_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  id_ex_operand_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_op_i(id_alu_op_i), .id_funct3_i(id_funct3_i),
    .id_funct7b5_i(id_funct7b5_i), .id_alu_src_i(id_alu_src_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_branch_i(id_branch_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
    .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .a_o(a_o), .b_o(b_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .rd_o(rd_o), .regwrite_o(regwrite_o),
    .memread_o(memread_o), .memwrite_o(memwrite_o),
    .memtoreg_o(memtoreg_o), .branch_o(branch_o)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit          valid;
    bit [63:0]   rs1d, rs2d, imm;
    bit [4:0]    rs1, rs2, rd;
    bit [3:0]    ctrl;
    bit          src, rw, mr, mw, mtr, br;
  } ex_t;
  ex_t m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [3:0] ref_ctrl(input bit [1:0] op, input bit [2:0] f3, input bit f7);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (f3 == 3'd7) return 4'd0;
    if (f3 == 3'd6) return 4'd1;
    if (op == 2'd2 && f3 == 3'd0 && f7) return 4'd6;
    return 4'd2;
  endfunction

  function automatic bit [63:0] ref_fwd(input bit [4:0] rs, input bit [63:0] rf);
    if (rs == 0) return rf;
    if (exmem_regwrite_i && exmem_rd_i == rs) return exmem_result_i;
    if (memwb_regwrite_i && memwb_rd_i == rs) return memwb_data_i;
    return rf;
  endfunction

  task automatic model_edge();
    ex_t z;
    z = '{default: '0};
    if (reset || flush_i) m = z;
    else if (!stall_i) begin
      m.valid = id_valid_i;
      m.rs1d  = id_rs1_data_i; m.rs2d = id_rs2_data_i; m.imm = id_imm_i;
      m.rs1   = id_rs1_i; m.rs2 = id_rs2_i; m.rd = id_rd_i;
      m.ctrl  = ref_ctrl(id_alu_op_i, id_funct3_i, id_funct7b5_i);
      m.src   = id_valid_i && id_alu_src_i;
      m.rw    = id_valid_i && id_regwrite_i;
      m.mr    = id_valid_i && id_memread_i;
      m.mw    = id_valid_i && id_memwrite_i;
      m.mtr   = id_valid_i && id_memtoreg_i;
      m.br    = id_valid_i && id_branch_i;
    end
  endtask

  task automatic compare_all(input string p);
    bit [63:0] ea, es;
    ea = ref_fwd(m.rs1, m.rs1d);
    es = ref_fwd(m.rs2, m.rs2d);
    chk({p, "_valid"}, {63'd0, valid_o}, {63'd0, m.valid});
    chk({p, "_a"}, a_o, ea);
    chk({p, "_b"}, b_o, m.src ? m.imm : es);
    chk({p, "_store"}, store_data_o, es);
    chk({p, "_ctrl"}, {60'd0, alu_ctrl_o}, {60'd0, m.ctrl});
    chk({p, "_rd"}, {59'd0, rd_o}, {59'd0, m.rd});
    chk({p, "_ctl"}, {59'd0, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o},
        {59'd0, m.rw, m.mr, m.mw, m.mtr, m.br});
  endtask

  // Inputs are set one time unit after an edge; check, take the edge, update model.
  task automatic cycle(input string p);
    #1;
    compare_all(p);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_id();
    id_valid_i    = ($urandom_range(0, 3) != 0);
    id_rs1_data_i = {$urandom, $urandom};
    id_rs2_data_i = {$urandom, $urandom};
    id_imm_i      = {$urandom, $urandom};
    id_rs1_i      = 5'($urandom_range(0, 3));
    id_rs2_i      = 5'($urandom_range(0, 3));
    id_rd_i       = 5'($urandom);
    id_alu_op_i   = 2'($urandom);
    id_funct3_i   = 3'($urandom);
    id_funct7b5_i = 1'($urandom);
    {id_alu_src_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i, id_branch_i} = 6'($urandom);
  endtask

  task automatic rand_fwd();
    exmem_regwrite_i = 1'($urandom);
    exmem_rd_i       = 5'($urandom_range(0, 3));
    exmem_result_i   = {$urandom, $urandom};
    memwb_regwrite_i = 1'($urandom);
    memwb_rd_i       = 5'($urandom_range(0, 3));
    memwb_data_i     = {$urandom, $urandom};
  endtask

  task automatic clear_id();
    {id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i} = '0;
    {id_alu_op_i, id_funct3_i, id_funct7b5_i, id_alu_src_i, id_regwrite_i} = '0;
    {id_memread_i, id_memwrite_i, id_memtoreg_i, id_branch_i} = '0;
    {exmem_regwrite_i, exmem_rd_i, exmem_result_i} = '0;
    {memwb_regwrite_i, memwb_rd_i, memwb_data_i} = '0;
  endtask

  initial begin
    m = '{default: '0};
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    clear_id();
    @(posedge clk); model_edge(); #1;
    cycle("rst");
    chk("rst_all", {a_o | b_o | store_data_o}, 64'd0);
    chk("rst_ctl", {53'd0, valid_o, alu_ctrl_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o, |rd_o}, 64'd0);
    reset = 1'b0;

    // R-type SUB
    id_valid_i = 1; id_alu_op_i = 2'b10; id_funct3_i = 3'b000; id_funct7b5_i = 1;
    id_rs1_data_i = 64'd10; id_rs2_data_i = 64'd3; id_rs1_i = 5'd1; id_rs2_i = 5'd2;
    id_rd_i = 5'd3; id_regwrite_i = 1;
    cycle("t1");
    chk("t1_ctrl", {60'd0, alu_ctrl_o}, 64'h6);
    chk("t1_a", a_o, 64'd10);
    chk("t1_b", b_o, 64'd3);
    chk("t1_valid", {63'd0, valid_o}, 64'd1);

    // I-arith AND with all-ones immediate
    id_alu_op_i = 2'b11; id_alu_src_i = 1; id_imm_i = '1; id_funct3_i = 3'b111;
    cycle("t2");
    chk("t2_ctrl", {60'd0, alu_ctrl_o}, 64'h0);
    chk("t2_b", b_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // forwarding priority on rs1=5, held in place by stall
    id_alu_src_i = 0; id_alu_op_i = 2'b10; id_funct3_i = 0; id_funct7b5_i = 0;
    id_rs1_i = 5'd5; id_rs1_data_i = 64'h1234;
    cycle("t3");
    stall_i = 1;
    exmem_regwrite_i = 1; exmem_rd_i = 5'd5; exmem_result_i = 64'h77;
    memwb_regwrite_i = 1; memwb_rd_i = 5'd5; memwb_data_i = 64'h11;
    #1 chk("t3_exmem", a_o, 64'h77);
    exmem_regwrite_i = 0;
    #1 chk("t3_memwb", a_o, 64'h11);
    cycle("t3s");
    stall_i = 0;

    // rd 0 never forwards
    clear_id();
    id_valid_i = 1; id_rs2_i = 5'd0; id_rs2_data_i = 64'h55; id_rs1_i = 5'd7;
    cycle("t4");
    exmem_regwrite_i = 1; exmem_rd_i = 5'd0; exmem_result_i = 64'h99;
    #1 chk("t4_store", store_data_o, 64'h55);

    // stall for 3 cycles while ID changes, then flush with stall
    clear_id();
    id_valid_i = 1; id_rs1_i = 5'd9; id_rs1_data_i = 64'hA5; id_rs2_i = 5'd10;
    id_rs2_data_i = 64'h5A; id_regwrite_i = 1; id_memwrite_i = 1; id_rd_i = 5'd4;
    cycle("t5");
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle("t5s");
      chk("t5_hold_a", a_o, 64'hA5);
      chk("t5_hold_rd", {59'd0, rd_o}, 64'd4);
      chk("t5_hold_mw", {63'd0, memwrite_o}, 64'd1);
    end
    flush_i = 1;
    cycle("t5f");
    chk("t5_flush", {61'd0, valid_o, regwrite_o, memwrite_o}, 64'd0);
    flush_i = 0; stall_i = 0;

    // reset mid-stall
    clear_id();
    id_valid_i = 1; id_rs1_data_i = 64'h3C; id_imm_i = 64'h8; id_alu_src_i = 1;
    id_regwrite_i = 1; id_branch_i = 1; id_rd_i = 5'd6; id_alu_op_i = 2'b01;
    cycle("t6");
    stall_i = 1;
    cycle("t6s");
    reset = 1;
    cycle("t6r");
    chk("t6_data", {a_o | b_o | store_data_o}, 64'd0);
    chk("t6_ctl", {53'd0, valid_o, alu_ctrl_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, branch_o, |rd_o}, 64'd0);
    reset = 0; stall_i = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      rand_id();
      rand_fwd();
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
